// File: rtl/if_id_buf_pkg.sv
// Shared constants for the IF/ID boundary.
// The NOP is addi x0,x0,0, which decode treats as having no register write.
package if_id_buf_pkg;

   localparam int          XLEN     = 32;
   localparam logic [31:0] INST_NOP = 32'h0000_0013;
   localparam logic [31:0] ADDR_NOP = 32'h0000_0000;

endpackage

// File: rtl/if_id_buf.sv
// IF/ID boundary: a 2-entry skid buffer between fetch and the combinational decode stage.
// The head entry is presented to decode, and a NOP is driven whenever no valid head exists.
module if_id_buf
   import if_id_buf_pkg::*;
#(
   parameter logic [XLEN-1:0] NOP_INST = INST_NOP,
   parameter logic [XLEN-1:0] NOP_ADDR = ADDR_NOP
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [XLEN-1:0] in_inst_addr_i,
   input  logic [XLEN-1:0] in_inst_i,
   input  logic            hold_i,
   input  logic            flush_i,
   output logic [XLEN-1:0] inst_addr_o,
   output logic [XLEN-1:0] inst_o,
   output logic            inst_valid_o
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_t;

   occ_t            state_reg, state_next;
   logic            rd_ptr_reg, rd_ptr_next;
   logic            wr_ptr_reg, wr_ptr_next;
   logic [XLEN-1:0] addr_mem [2];
   logic [XLEN-1:0] inst_mem [2];
   logic            push, pop;

   assign push = in_valid_i & in_ready_o & ~flush_i;
   assign pop  = inst_valid_o & ~hold_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= EMPTY;
         rd_ptr_reg <= 1'b0;
         wr_ptr_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         rd_ptr_reg <= rd_ptr_next;
         wr_ptr_reg <= wr_ptr_next;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr_reg] <= in_inst_addr_i;
         inst_mem[wr_ptr_reg] <= in_inst_i;
      end
   end

   always_comb begin
      state_next  = state_reg;
      rd_ptr_next = rd_ptr_reg;
      wr_ptr_next = wr_ptr_reg;
      if (flush_i) begin
         state_next  = EMPTY;
         rd_ptr_next = 1'b0;
         wr_ptr_next = 1'b0;
      end else begin
         if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
         unique case (state_reg)
            EMPTY:   if (push) state_next = ONE;
            ONE: begin
               if (push && !pop)      state_next = FULL;
               else if (!push && pop) state_next = EMPTY;
            end
            FULL:    if (pop) state_next = ONE;
            default: state_next = EMPTY;
         endcase
      end
   end

   // Ready looks only at registered state so fetch never sees a path from hold/flush.
   always_comb begin
      in_ready_o   = (state_reg != FULL);
      inst_valid_o = (state_reg != EMPTY) && !flush_i;
      inst_addr_o  = NOP_ADDR;
      inst_o       = NOP_INST;
      if (inst_valid_o) begin
         inst_addr_o = addr_mem[rd_ptr_reg];
         inst_o      = inst_mem[rd_ptr_reg];
      end
   end

endmodule

// File: tb/tb_if_id_buf.sv
// Bench for if_id_buf: a directed vector table followed by random traffic
// checked against a queue-based model of the buffer.
module tb_if_id_buf;

   localparam logic [31:0] NI = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst, in_valid_i, in_ready_o, hold_i, flush_i, inst_valid_o;
   logic [31:0] in_inst_addr_i, in_inst_i, inst_addr_o, inst_o;

   int n_cmp = 0;
   int n_err = 0;

   if_id_buf dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid_i     (in_valid_i),
      .in_ready_o     (in_ready_o),
      .in_inst_addr_i (in_inst_addr_i),
      .in_inst_i      (in_inst_i),
      .hold_i         (hold_i),
      .flush_i        (flush_i),
      .inst_addr_o    (inst_addr_o),
      .inst_o         (inst_o),
      .inst_valid_o   (inst_valid_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        r, v, h, f, chk;
      logic [31:0] a, i;
      logic        e_rdy, e_vld;
      logic [31:0] e_a, e_i;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic v, input logic [31:0] a, input logic [31:0] i,
                      input logic h, input logic f, input logic chk,
                      input logic e_rdy, input logic e_vld, input logic [31:0] e_a,
                      input logic [31:0] e_i);
      vec_t x;
      x.r = r; x.v = v; x.a = a; x.i = i; x.h = h; x.f = f; x.chk = chk;
      x.e_rdy = e_rdy; x.e_vld = e_vld; x.e_a = e_a; x.e_i = e_i;
      vecs.push_back(x);
   endtask

   task automatic check(input string name, input int step, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic v, input logic [31:0] a, input logic [31:0] i,
                        input logic h, input logic f);
      rst = r; in_valid_i = v; in_inst_addr_i = a; in_inst_i = i; hold_i = h; flush_i = f;
   endtask

   typedef struct { logic [31:0] a, i; } ent_t;

   initial begin
      ent_t q[$];
      ent_t e;
      logic r, v, h, f, m_rdy, m_vld;
      logic [31:0] a, i, m_a, m_i;

      drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

      //  r  v  addr   inst           h  f  chk  rdy vld  e_addr  e_inst
      // reset with fetch offering
      add(1, 1, 32'h100, 32'hDEAD_BEEF, 0, 0, 0, 1, 0, 32'h0, NI);
      add(1, 1, 32'h100, 32'hDEAD_BEEF, 0, 0, 1, 1, 0, 32'h0, NI);
      add(0, 0, 32'h0,   32'h0,         0, 0, 1, 1, 0, 32'h0, NI);
      // streaming
      add(0, 1, 32'h0,   32'h0050_0093, 0, 0, 1, 1, 0, 32'h0, NI);
      add(0, 1, 32'h4,   32'h00A0_0113, 0, 0, 1, 1, 1, 32'h0, 32'h0050_0093);
      add(0, 1, 32'h8,   32'h0020_81B3, 0, 0, 1, 1, 1, 32'h4, 32'h00A0_0113);
      add(0, 0, 32'h0,   32'h0,         0, 0, 1, 1, 1, 32'h8, 32'h0020_81B3);
      add(0, 0, 32'h0,   32'h0,         0, 0, 1, 1, 0, 32'h0, NI);
      // stall fill then drain
      add(0, 1, 32'h10,  32'h1111_1111, 1, 0, 1, 1, 0, 32'h0,  NI);
      add(0, 1, 32'h14,  32'h2222_2222, 1, 0, 1, 1, 1, 32'h10, 32'h1111_1111);
      add(0, 1, 32'h18,  32'h3333_3333, 1, 0, 1, 0, 1, 32'h10, 32'h1111_1111);
      add(0, 0, 32'h0,   32'h0,         0, 0, 1, 0, 1, 32'h10, 32'h1111_1111);
      add(0, 0, 32'h0,   32'h0,         0, 0, 1, 1, 1, 32'h14, 32'h2222_2222);
      add(0, 0, 32'h0,   32'h0,         0, 0, 1, 1, 0, 32'h0,  NI);
      // flush while full with a concurrent offer of 0x20
      add(0, 1, 32'h18,  32'h4444_4444, 1, 0, 1, 1, 0, 32'h0,  NI);
      add(0, 1, 32'h1C,  32'h5555_5555, 1, 0, 1, 1, 1, 32'h18, 32'h4444_4444);
      add(0, 1, 32'h20,  32'h6666_6666, 1, 1, 1, 0, 0, 32'h0,  NI);
      add(0, 0, 32'h0,   32'h0,         0, 0, 1, 1, 0, 32'h0,  NI);
      add(0, 0, 32'h0,   32'h0,         0, 0, 1, 1, 0, 32'h0,  NI);
      // flush overrides hold in ONE
      add(0, 1, 32'h30,  32'h7777_7777, 0, 0, 1, 1, 0, 32'h0,  NI);
      add(0, 0, 32'h0,   32'h0,         1, 1, 1, 1, 0, 32'h0,  NI);
      add(0, 0, 32'h0,   32'h0,         0, 0, 1, 1, 0, 32'h0,  NI);
      // reset while full and stalled
      add(0, 1, 32'h40,  32'h8888_8888, 1, 0, 1, 1, 0, 32'h0,  NI);
      add(0, 1, 32'h44,  32'h9999_9999, 1, 0, 1, 1, 1, 32'h40, 32'h8888_8888);
      add(1, 1, 32'h48,  32'hAAAA_AAAA, 1, 0, 1, 0, 1, 32'h40, 32'h8888_8888);
      add(0, 0, 32'h0,   32'h0,         1, 0, 1, 1, 0, 32'h0,  NI);
      add(0, 0, 32'h0,   32'h0,         0, 0, 1, 1, 0, 32'h0,  NI);

      foreach (vecs[k]) begin
         @(negedge clk);
         drive(vecs[k].r, vecs[k].v, vecs[k].a, vecs[k].i, vecs[k].h, vecs[k].f);
         #2;
         if (vecs[k].chk) begin
            check("ready", k, {31'b0, in_ready_o},   {31'b0, vecs[k].e_rdy});
            check("valid", k, {31'b0, inst_valid_o}, {31'b0, vecs[k].e_vld});
            check("addr",  k, inst_addr_o, vecs[k].e_a);
            check("inst",  k, inst_o,      vecs[k].e_i);
         end
         $display("vec %0d: r=%b v=%b h=%b f=%b -> rdy=%b vld=%b addr=%h inst=%h",
                  k, vecs[k].r, vecs[k].v, vecs[k].h, vecs[k].f,
                  in_ready_o, inst_valid_o, inst_addr_o, inst_o);
      end

      // Random traffic; model state after the table is empty.
      q.delete();
      for (int c = 0; c < 3000; c++) begin
         r = ($urandom_range(0, 63) == 0);
         f = ($urandom_range(0, 9) == 0);
         h = ($urandom_range(0, 2) == 0);
         v = ($urandom_range(0, 2) != 0);
         a = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
         i = $urandom;
         @(negedge clk);
         drive(r, v, a, i, h, f);
         #2;
         m_rdy = (q.size() < 2);
         m_vld = (q.size() > 0) && !f;
         m_a   = m_vld ? q[0].a : 32'h0;
         m_i   = m_vld ? q[0].i : NI;
         check("rnd_ready", c, {31'b0, in_ready_o},   {31'b0, m_rdy});
         check("rnd_valid", c, {31'b0, inst_valid_o}, {31'b0, m_vld});
         check("rnd_addr",  c, inst_addr_o, m_a);
         check("rnd_inst",  c, inst_o,      m_i);
         if (c % 100 == 0)
            $display("rnd %0d: r=%b v=%b h=%b f=%b -> rdy=%b vld=%b addr=%h",
                     c, r, v, h, f, in_ready_o, inst_valid_o, inst_addr_o);
         if (r || f) begin
            q.delete();
         end else begin
            if (m_vld && !h) void'(q.pop_front());
            if (v && m_rdy) begin
               e.a = a; e.i = i;
               q.push_back(e);
            end
         end
      end

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
